// File: rtl/vector_reduction_unit_if.sv
// Handshake bundle between the SIMD ALU result stream,
// the reduction unit and the scalar writeback consumer.
interface vector_reduction_unit_if #(
    parameter int BEAT_WIDTH = 8
);
    logic                  clear;
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_data;
    logic                  in_signed;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_sum;
    logic [BEAT_WIDTH-1:0] out_beats;
    logic                  out_overflow;

    modport master (
        output clear, in_valid, in_data, in_signed, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_beats, out_overflow
    );

    modport slave (
        input  clear, in_valid, in_data, in_signed, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_beats, out_overflow
    );
endinterface

// File: rtl/vector_reduction_unit.sv
// Per-lane accumulation of packed 4x8 SIMD beats followed by a
// two-step horizontal reduction to one 32-bit sum.
module vector_reduction_unit #(
    parameter int ACC_WIDTH  = 16,
    parameter int BEAT_WIDTH = 8
) (
    input logic                    clk,
    input logic                    reset,
    vector_reduction_unit_if.slave bus
);
    typedef enum logic [1:0] {ACCUM, RED1, RED2, OUT} state_t;

    state_t state_q, state_d;

    logic [3:0][ACC_WIDTH-1:0] acc_q;
    logic [3:0][ACC_WIDTH-1:0] acc_nx;
    logic [3:0]                lane_ovf;
    logic [ACC_WIDTH:0]        p0_q, p1_q;
    logic [ACC_WIDTH:0]        p0_nx, p1_nx;
    logic [ACC_WIDTH+1:0]      red_sum;
    logic [31:0]               sum_nx;
    logic [BEAT_WIDTH-1:0]     cnt_q;
    logic                      ovf_q;
    logic                      mode_q;
    logic                      beat_mode;
    logic                      xfer;
    logic [31:0]               out_sum_q;
    logic [BEAT_WIDTH-1:0]     out_beats_q;
    logic                      out_ovf_q;

    assign bus.in_ready     = (state_q == ACCUM);
    assign bus.out_valid    = (state_q == OUT);
    assign bus.out_sum      = out_sum_q;
    assign bus.out_beats    = out_beats_q;
    assign bus.out_overflow = out_ovf_q;

    assign xfer = bus.in_valid & bus.in_ready;

    // first beat of a packet decides the mode for the whole packet
    assign beat_mode = (cnt_q == '0) ? bus.in_signed : mode_q;

    // lane add with wrap, plus carry / signed-overflow detection
    always_comb begin
        logic [ACC_WIDTH-1:0] ext;
        logic [ACC_WIDTH:0]   sum;
        acc_nx   = acc_q;
        lane_ovf = '0;
        ext      = '0;
        sum      = '0;
        for (int i = 0; i < 4; i++) begin
            if (beat_mode)
                ext = ACC_WIDTH'($signed(bus.in_data[8*i +: 8]));
            else
                ext = ACC_WIDTH'(bus.in_data[8*i +: 8]);
            sum = {1'b0, acc_q[i]} + {1'b0, ext};
            acc_nx[i] = sum[ACC_WIDTH-1:0];
            if (beat_mode)
                lane_ovf[i] = (acc_q[i][ACC_WIDTH-1] == ext[ACC_WIDTH-1])
                            & (sum[ACC_WIDTH-1] != acc_q[i][ACC_WIDTH-1]);
            else
                lane_ovf[i] = sum[ACC_WIDTH];
        end
    end

    // pairwise then final reduction, widened by one bit per level
    always_comb begin
        p0_nx = {mode_q & acc_q[0][ACC_WIDTH-1], acc_q[0]}
              + {mode_q & acc_q[1][ACC_WIDTH-1], acc_q[1]};
        p1_nx = {mode_q & acc_q[2][ACC_WIDTH-1], acc_q[2]}
              + {mode_q & acc_q[3][ACC_WIDTH-1], acc_q[3]};
        red_sum = {mode_q & p0_q[ACC_WIDTH], p0_q}
                + {mode_q & p1_q[ACC_WIDTH], p1_q};
        if (mode_q)
            sum_nx = 32'($signed(red_sum));
        else
            sum_nx = 32'(red_sum);
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= ACCUM;
        else
            state_q <= state_d;
    end

    // next-state logic; clear overrides every handshake
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM: if (xfer && bus.in_last) state_d = RED1;
            RED1:  state_d = RED2;
            RED2:  state_d = OUT;
            OUT:   if (bus.out_ready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
        if (bus.clear)
            state_d = ACCUM;
    end

    // accumulators, partial sums and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            p0_q        <= '0;
            p1_q        <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            mode_q      <= 1'b0;
            out_sum_q   <= '0;
            out_beats_q <= '0;
            out_ovf_q   <= 1'b0;
        end else if (bus.clear) begin
            acc_q       <= '0;
            p0_q        <= '0;
            p1_q        <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            mode_q      <= 1'b0;
            out_sum_q   <= '0;
            out_beats_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (xfer) begin
                        acc_q <= acc_nx;
                        ovf_q <= ovf_q | (|lane_ovf);
                        if (cnt_q == '0)
                            mode_q <= bus.in_signed;
                        if (cnt_q != '1)
                            cnt_q <= cnt_q + 1'b1;
                    end
                end
                RED1: begin
                    p0_q <= p0_nx;
                    p1_q <= p1_nx;
                end
                RED2: begin
                    out_sum_q   <= sum_nx;
                    out_beats_q <= cnt_q;
                    out_ovf_q   <= ovf_q;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        acc_q  <= '0;
                        cnt_q  <= '0;
                        ovf_q  <= 1'b0;
                        mode_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
